kbd_scan_decoder: RTL and testbench

Upstream stage of the keyboard LED FSM. Takes the PS/2 Set-2 scan-code byte stream from the PS/2 byte receiver and produces three outputs:
- a 512-bit key-state bitmap,
- the 9-bit code of the most recently changed key,
- a one-cycle valid strobe.

It resolves the E0 (extended) and F0 (break) prefixes, discards the E1 Pause sequence, and times out stale prefixes.

---
 rtl/kbd_scan_decoder_if.sv | 35 +++
 rtl/kbd_scan_decoder.sv | 168 ++++++++++++++++
 tb/tb_kbd_scan_decoder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/kbd_scan_decoder_if.sv
// Byte stream from the PS/2 receiver into the decoder, and the key-state
// results going back out to the LED FSM.
//
// Handshake: rx_valid is a one-cycle strobe that qualifies rx_data. There is
// no ready; the decoder accepts one byte on every cycle rx_valid is high.
// key_valid and timeout_err are one-cycle pulses, and key_down/last_change
// already hold their new values when key_valid is high.
interface kbd_scan_decoder_if;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic         timeout_err;

  // Byte source side (PS/2 receiver plus the consumer of the key state).
  modport master (
    output rx_data,
    output rx_valid,
    input  key_down,
    input  last_change,
    input  key_valid,
    input  timeout_err
  );

  // Decoder side.
  modport slave (
    input  rx_data,
    input  rx_valid,
    output key_down,
    output last_change,
    output key_valid,
    output timeout_err
  );
endinterface

// File: rtl/kbd_scan_decoder.sv
// PS/2 Set-2 scan-code decoder. It resolves the E0 (extended) and F0 (break)
// prefixes into make/break events for key {ext, code}, and keeps a 512-bit
// held-key bitmap. It drops the E1 Pause sequence, and a stale prefix
// returns to IDLE after TIMEOUT_CYCLES idle cycles.
module kbd_scan_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned PAUSE_SKIP     = 7
) (
  input  logic               clk,
  input  logic               rst,
  kbd_scan_decoder_if.slave  bus,
  output logic [2:0]         state_o
);

  localparam int CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SKIP_W = $clog2(PAUSE_SKIP + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(PAUSE_SKIP);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    tmo_cnt_q;
  logic [SKIP_W-1:0]   skip_q;
  logic [511:0]        key_down_q;
  logic [8:0]          last_change_q;
  logic                key_valid_q;
  logic                timeout_err_q;

  logic                expire;
  logic                act_make;
  logic                act_break;
  logic [8:0]          act_key;
  logic                key_hit;

  // Controller responses and acks that never name a key.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) || (b == 8'hFC) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  // A prefix/skip state expires only on a cycle with no byte; a byte that
  // arrives on the expiry cycle wins.
  assign expire = (state_q != ST_IDLE) && !bus.rx_valid && (tmo_cnt_q == CNT_MAX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode from the current prefix state and the accepted byte.
  always_comb begin
    state_d = state_q;
    if (bus.rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.rx_data == 8'hE0)      state_d = ST_EXT;
          else if (bus.rx_data == 8'hF0) state_d = ST_BRK;
          else if (bus.rx_data == 8'hE1) state_d = ST_SKIP;
          else                           state_d = ST_IDLE;
        end
        ST_EXT: begin
          if (bus.rx_data == 8'hF0)      state_d = ST_EXT_BRK;
          else if (bus.rx_data == 8'hE0) state_d = ST_EXT;
          else                           state_d = ST_IDLE;
        end
        ST_BRK: begin
          if (bus.rx_data == 8'hF0) state_d = ST_BRK;
          else                      state_d = ST_IDLE;
        end
        ST_EXT_BRK: state_d = ST_IDLE;
        ST_SKIP: begin
          if (skip_q <= SKIP_W'(1)) state_d = ST_IDLE;
          else                      state_d = ST_SKIP;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (expire) begin
      state_d = ST_IDLE;
    end
  end

  // Key actions: which make/break event (if any) this byte produces.
  always_comb begin
    act_make  = 1'b0;
    act_break = 1'b0;
    act_key   = {1'b0, bus.rx_data};
    if (bus.rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.rx_data != 8'hE0 && bus.rx_data != 8'hF0 &&
              bus.rx_data != 8'hE1 && !is_ignored(bus.rx_data))
            act_make = 1'b1;
        end
        ST_EXT: begin
          act_key = {1'b1, bus.rx_data};
          // E0 12 is the fake left-shift some keyboards emit; not a key.
          if (bus.rx_data != 8'hF0 && bus.rx_data != 8'hE0 && bus.rx_data != 8'h12)
            act_make = 1'b1;
        end
        ST_BRK: begin
          if (bus.rx_data != 8'hF0) act_break = 1'b1;
        end
        ST_EXT_BRK: begin
          act_key = {1'b1, bus.rx_data};
          if (bus.rx_data != 8'h12) act_break = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Only real transitions of the bitmap are reported; typematic repeats and
  // breaks of keys not held are swallowed.
  assign key_hit = (act_make && !key_down_q[act_key]) || (act_break && key_down_q[act_key]);

  // Inter-byte timeout counter: runs only while waiting for the next byte
  // of a multi-byte code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         tmo_cnt_q <= '0;
    else if (bus.rx_valid || state_q == ST_IDLE || expire) tmo_cnt_q <= '0;
    else                                             tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
  end

  // Pause-sequence byte countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_q <= '0;
    end else if (bus.rx_valid && state_q == ST_IDLE && bus.rx_data == 8'hE1) begin
      skip_q <= SKIP_LOAD;
    end else if (bus.rx_valid && state_q == ST_SKIP) begin
      skip_q <= (skip_q == '0) ? '0 : skip_q - SKIP_W'(1);
    end else if (expire) begin
      skip_q <= '0;
    end
  end

  // Key bitmap, last changed key and the registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_down_q    <= '0;
      last_change_q <= '0;
      key_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      key_valid_q   <= key_hit;
      timeout_err_q <= expire;
      if (key_hit) begin
        key_down_q[act_key] <= act_make;
        last_change_q       <= act_key;
      end
    end
  end

  assign bus.key_down    = key_down_q;
  assign bus.last_change = last_change_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.timeout_err = timeout_err_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Directed scan-code sequences for the decoder. Expected key events are
// queued as bytes are sent; a monitor retires them when pulses appear.
module tb_kbd_scan_decoder;
  localparam int TMO = 16;
  localparam int W   = 43; // {cycle[31:0], is_timeout, key_value, key[8:0]}

  // Clock and reset
  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kbd_scan_decoder_if bus();
  logic [2:0] state_dbg;

  kbd_scan_decoder #(
    .TIMEOUT_CYCLES (TMO),
    .PAUSE_SKIP     (7)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.key_valid || bus.timeout_err) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_pulse: key_valid=%0b timeout_err=%0b last_change=%0h (cycle %0d)",
                 bus.key_valid, bus.timeout_err, bus.last_change, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", 64'(cyc), 64'(e[42:11]));
        check("timeout_err", 64'(bus.timeout_err), 64'(e[10]));
        check("key_valid", 64'(bus.key_valid), 64'(!e[10]));
        if (!e[10]) begin
          check("last_change", 64'(bus.last_change), 64'(e[8:0]));
          check("key_down_bit", 64'(bus.key_down[e[8:0]]), 64'(e[9]));
        end
      end
    end
  end

  // Driver tasks
  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_ev(input logic [7:0] b, input logic [8:0] key, input logic val);
    exp_q.push_back({cyc + 32'd1, 1'b0, val, key});
    send(b);
  endtask

  task automatic expect_tmo(input int unsigned at);
    exp_q.push_back({32'(at), 1'b1, 1'b0, 9'h000});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int unsigned c0;

  initial begin
    rst          = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_key_down", 64'(|bus.key_down), 64'd0);
    check("rst_last_change", 64'(bus.last_change), 64'd0);
    check("rst_key_valid", 64'(bus.key_valid), 64'd0);
    check("rst_timeout_err", 64'(bus.timeout_err), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    rst = 1'b0;
    idle(2);

    // Plain make and break
    send_ev(8'h58, 9'h058, 1'b1);
    idle(2);
    check("t1_make_held", 64'(bus.key_down[9'h058]), 64'd1);
    send(8'hF0);
    send_ev(8'h58, 9'h058, 1'b0);
    idle(2);
    check("t1_break_clear", 64'(bus.key_down[9'h058]), 64'd0);

    // Controller responses produce nothing
    send(8'hAA);
    send(8'hFA);
    send(8'h00);
    idle(2);
    check("ignored_bytes", 64'(|bus.key_down), 64'd0);

    // Extended Up arrow
    send(8'hE0);
    send_ev(8'h75, 9'h175, 1'b1);
    idle(2);
    check("t2_ext_held", 64'(bus.key_down[9'h175]), 64'd1);
    check("t2_base_clear", 64'(bus.key_down[9'h075]), 64'd0);
    send(8'hE0);
    send(8'hF0);
    send_ev(8'h75, 9'h175, 1'b0);
    idle(2);
    check("t2_ext_clear", 64'(bus.key_down[9'h175]), 64'd0);
    check("t2_base_still_clear", 64'(bus.key_down[9'h075]), 64'd0);

    // Fake shift make and break are ignored
    send(8'hE0);
    send(8'h12);
    send(8'hE0);
    send(8'hF0);
    send(8'h12);
    idle(2);
    check("fake_shift_012", 64'(bus.key_down[9'h012]), 64'd0);
    check("fake_shift_112", 64'(bus.key_down[9'h112]), 64'd0);
    check("fake_shift_idle", 64'(state_dbg), 64'd0);

    // Typematic repeats on back-to-back cycles
    send_ev(8'h1C, 9'h01C, 1'b1);
    send(8'h1C);
    send(8'h1C);
    check("t3_typematic_held", 64'(bus.key_down[9'h01C]), 64'd1);
    send(8'hF0);
    send_ev(8'h1C, 9'h01C, 1'b0);
    idle(2);
    check("t3_released", 64'(bus.key_down[9'h01C]), 64'd0);

    // Pause sequence is drained, following key decodes normally
    send(8'hE1);
    send(8'h14);
    send(8'h77);
    send(8'hE1);
    send(8'hF0);
    send(8'h14);
    send(8'hF0);
    send(8'h77);
    send_ev(8'h29, 9'h029, 1'b1);
    idle(2);
    check("t4_pause_014", 64'(bus.key_down[9'h014]), 64'd0);
    check("t4_pause_077", 64'(bus.key_down[9'h077]), 64'd0);
    check("t4_make_029", 64'(bus.key_down[9'h029]), 64'd1);

    // Stale F0 times out; the byte afterwards is a make
    c0 = cyc;
    expect_tmo(c0 + 17);
    send(8'hF0);
    idle(20);
    check("t5_state_idle", 64'(state_dbg), 64'd0);
    send_ev(8'h58, 9'h058, 1'b1);
    idle(2);
    check("t5_make_after_tmo", 64'(bus.key_down[9'h058]), 64'd1);

    // Byte on the expiry cycle is still a break, no timeout
    c0 = cyc;
    send(8'hF0);
    idle(15);
    check("t5_at_expiry_cycle", 64'(cyc), 64'(c0 + 16));
    send_ev(8'h58, 9'h058, 1'b0);
    idle(20);
    check("t5_break_at_expiry", 64'(bus.key_down[9'h058]), 64'd0);

    // Reset in the middle of an extended code
    send_ev(8'h1C, 9'h01C, 1'b1);
    send(8'hE0);
    send_ev(8'h75, 9'h175, 1'b1);
    idle(2);
    check("t6_held_01c", 64'(bus.key_down[9'h01C]), 64'd1);
    send(8'hE0);
    rst = 1'b1;
    #1;
    check("t6_rst_key_down", 64'(|bus.key_down), 64'd0);
    check("t6_rst_key_valid", 64'(bus.key_valid), 64'd0);
    check("t6_rst_state", 64'(state_dbg), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    send_ev(8'h58, 9'h058, 1'b1);
    idle(3);
    check("t6_make_after_rst", 64'(bus.key_down[9'h058]), 64'd1);
    check("t6_not_extended", 64'(bus.key_down[9'h158]), 64'd0);

    idle(5);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
